// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters.
// Holds the FSM encoding, the double-dabble constants and the default sizes.
package bcd_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StConvert
    } bcd_state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] DABBLE_THRESH = 4'd8;
    localparam logic [3:0] DABBLE_ADJ    = 4'd3;

    localparam int unsigned DEFAULT_DIGITS    = 3;
    localparam int unsigned DEFAULT_BIN_WIDTH = 10;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-digit correction step for reverse double-dabble.
// It subtracts 3 from a nibble that reached 8 or more after the right shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= DABBLE_THRESH) begin
            adjusted = nibble - DABBLE_ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out, one bit per clock.
// The start/busy/done handshake controls each conversion; invalid digits are flagged through err.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = DEFAULT_DIGITS,
    parameter int unsigned BIN_WIDTH = DEFAULT_BIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIGITS*4-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_WIDTH-1:0]  binary_out,
    output logic                  err
);

    localparam int unsigned BcdW = DIGITS * 4;
    localparam int unsigned RegW = BcdW + BIN_WIDTH;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

    bcd_state_e           state_q, state_d;
    logic [RegW-1:0]      work_q, work_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;

    logic [RegW-1:0]      shifted;
    logic [BcdW-1:0]      adj_bcd;
    logic [RegW-1:0]      stepped;
    logic                 bad_digit;

    assign shifted = work_q >> 1;

    // Every digit is corrected in parallel on the same edge as the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .nibble  (shifted[BIN_WIDTH + 4*g +: 4]),
            .adjusted(adj_bcd[4*g +: 4])
        );
    end

    assign stepped = {adj_bcd, shifted[BIN_WIDTH-1:0]};

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bad_digit = bad_digit | (bcd_in[4*i +: 4] > BCD_DIGIT_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bin_d   = bin_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (bad_digit) begin
                        bin_d  = '0;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        work_d  = {bcd_in, {BIN_WIDTH{1'b0}}};
                        cnt_d   = CntW'(BIN_WIDTH);
                        err_d   = 1'b0;
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                work_d = stepped;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bin_d   = stepped[BIN_WIDTH-1:0];
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy       = (state_q == StConvert);
    assign done       = done_q;
    assign err        = err_q;
    assign binary_out = bin_q;

endmodule
